// File: rtl/i2c_globals_pkg.sv
// Shared widths, bus direction and receive-FSM types for the I2C target path.
package i2c_globals_pkg;
  localparam int SLAVE_ADDRESS_WIDTH    = 7;
  localparam int REGISTER_ADDRESS_WIDTH = 8;
  localparam int DATA_WIDTH             = 8;
  localparam int MAXIMUM_BYTES          = 128;
  localparam int FRAME_WIDTH            = 8;
  localparam int BYTE_INDEX_WIDTH       = $clog2(MAXIMUM_BYTES);
  localparam int TXN_BYTES_WIDTH        = BYTE_INDEX_WIDTH + 1;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } read_write_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_target_rx_state_e;

  typedef struct packed {
    logic [REGISTER_ADDRESS_WIDTH-1:0] register_address;
    logic [DATA_WIDTH-1:0]             data;
  } i2c_reg_write_t;

  function automatic logic addr_hit(
    input logic [FRAME_WIDTH-1:0]         frame,
    input logic [SLAVE_ADDRESS_WIDTH-1:0] own
  );
    return (frame[FRAME_WIDTH-1:1] == own) &&
           (read_write_e'(frame[0]) == WRITE);
  endfunction
endpackage

// File: rtl/i2c_bus_event_detect.sv
// SCL/SDA synchroniser plus START/STOP and SCL edge pulse generation.
module i2c_bus_event_detect (
  input  logic pclk,
  input  logic areset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic start_det,
  output logic stop_det,
  output logic scl_rise,
  output logic scl_fall
);
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge pclk) begin
    if (areset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_target_write_rx.sv
// I2C target write receiver: address match, register byte, streamed data.
// Define I2C_TARGET_CLK_STRETCH_EN to stretch SCL instead of dropping bytes.
module i2c_target_write_rx
  import i2c_globals_pkg::*;
(
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic                              scl_oe,
  input  logic [SLAVE_ADDRESS_WIDTH-1:0]    own_addr,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr,
  output logic                              reg_addr_valid,
  output logic [DATA_WIDTH-1:0]             data,
  output logic                              data_valid,
  input  logic                              data_ready,
  output logic [BYTE_INDEX_WIDTH-1:0]       byte_index,
  output logic                              txn_done,
  output logic [TXN_BYTES_WIDTH-1:0]        txn_bytes,
  output logic                              overflow_err
);
  logic sda_s, start_det, stop_det, scl_rise, scl_fall;

  i2c_target_rx_state_e state_q, state_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [FRAME_WIDTH-1:0]      shift_q, shift_d;
  logic                        sda_oe_q, sda_oe_d;
  logic                        scl_oe_q, scl_oe_d;
  logic                        stretch_q, stretch_d;
  logic [TXN_BYTES_WIDTH-1:0]  count_q, count_d;
  logic                        reg_seen_q, reg_seen_d;
  i2c_reg_write_t              xfer_q, xfer_d;
  logic                        reg_addr_valid_q, reg_addr_valid_d;
  logic                        data_valid_q, data_valid_d;
  logic [BYTE_INDEX_WIDTH-1:0] byte_index_q, byte_index_d;
  logic                        txn_done_q, txn_done_d;
  logic [TXN_BYTES_WIDTH-1:0]  txn_bytes_q, txn_bytes_d;
  logic                        overflow_q, overflow_d;

  logic                   byte_done;
  logic                   slot_free;
  logic                   load_en;
  logic [FRAME_WIDTH-1:0] load_byte;
  logic [FRAME_WIDTH-1:0] new_byte;

  i2c_bus_event_detect u_evt (
    .pclk      (pclk),
    .areset    (areset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall)
  );

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    sda_oe_d         = sda_oe_q;
    scl_oe_d         = scl_oe_q;
    stretch_d        = stretch_q;
    count_d          = count_q;
    reg_seen_d       = reg_seen_q;
    xfer_d           = xfer_q;
    reg_addr_valid_d = 1'b0;
    data_valid_d     = data_valid_q & ~data_ready;
    byte_index_d     = byte_index_q;
    txn_done_d       = 1'b0;
    txn_bytes_d      = txn_bytes_q;
    overflow_d       = overflow_q;
    byte_done        = 1'b0;
    load_en          = 1'b0;
    load_byte        = shift_q;
    new_byte         = {shift_q[FRAME_WIDTH-2:0], sda_s};
    slot_free        = ~data_valid_q | data_ready;

    if (scl_rise && (state_q inside {ADDR, REG, DATA})) begin
      shift_d   = new_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    unique case (state_q)
      IDLE: ;
      ADDR: begin
        if (byte_done)
          state_d = addr_hit(new_byte, own_addr) ? ADDR_ACK : IGNORE;
      end
      REG: begin
        if (byte_done) begin
          xfer_d.register_address = new_byte;
          reg_addr_valid_d        = 1'b1;
          reg_seen_d              = 1'b1;
          state_d                 = REG_ACK;
        end
      end
      DATA: begin
        if (byte_done) begin
          if (count_q == TXN_BYTES_WIDTH'(MAXIMUM_BYTES)) begin
            state_d = IGNORE;
          end else if (slot_free) begin
            load_en   = 1'b1;
            load_byte = new_byte;
            state_d   = DATA_ACK;
          end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
            stretch_d = 1'b1;
            state_d   = DATA_ACK;
`else
            overflow_d = 1'b1;
            state_d    = IGNORE;
`endif
          end
        end
      end
      ADDR_ACK, REG_ACK, DATA_ACK: begin
        // A held byte waits in shift_q; SCL is held once the bus falls.
        if (stretch_q) begin
          if (slot_free) begin
            load_en   = 1'b1;
            stretch_d = 1'b0;
            if (scl_oe_q || scl_fall) begin
              scl_oe_d = 1'b0;
              sda_oe_d = 1'b1;
            end
          end else if (scl_fall) begin
            scl_oe_d = 1'b1;
          end
        end else if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = (state_q == ADDR_ACK) ? REG : DATA;
          end
        end
      end
      IGNORE: sda_oe_d = 1'b0;
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      xfer_d.data  = load_byte;
      data_valid_d = 1'b1;
      byte_index_d = count_q[BYTE_INDEX_WIDTH-1:0];
      count_d      = count_q + TXN_BYTES_WIDTH'(1);
    end

    if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = 3'd0;
      overflow_d = 1'b0;
      count_d    = '0;
      reg_seen_d = 1'b0;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      stretch_d  = 1'b0;
    end else if (stop_det) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      stretch_d  = 1'b0;
      reg_seen_d = 1'b0;
      if (reg_seen_q) begin
        txn_done_d  = 1'b1;
        txn_bytes_d = count_q;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q          <= IDLE;
      bit_cnt_q        <= 3'd0;
      shift_q          <= '0;
      sda_oe_q         <= 1'b0;
      scl_oe_q         <= 1'b0;
      stretch_q        <= 1'b0;
      count_q          <= '0;
      reg_seen_q       <= 1'b0;
      xfer_q           <= '0;
      reg_addr_valid_q <= 1'b0;
      data_valid_q     <= 1'b0;
      byte_index_q     <= '0;
      txn_done_q       <= 1'b0;
      txn_bytes_q      <= '0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      sda_oe_q         <= sda_oe_d;
      scl_oe_q         <= scl_oe_d;
      stretch_q        <= stretch_d;
      count_q          <= count_d;
      reg_seen_q       <= reg_seen_d;
      xfer_q           <= xfer_d;
      reg_addr_valid_q <= reg_addr_valid_d;
      data_valid_q     <= data_valid_d;
      byte_index_q     <= byte_index_d;
      txn_done_q       <= txn_done_d;
      txn_bytes_q      <= txn_bytes_d;
      overflow_q       <= overflow_d;
    end
  end

  assign sda_oe         = sda_oe_q;
  assign scl_oe         = scl_oe_q;
  assign reg_addr       = xfer_q.register_address;
  assign reg_addr_valid = reg_addr_valid_q;
  assign data           = xfer_q.data;
  assign data_valid     = data_valid_q;
  assign byte_index     = byte_index_q;
  assign txn_done       = txn_done_q;
  assign txn_bytes      = txn_bytes_q;
  assign overflow_err   = overflow_q;
endmodule

// File: tb/tb_i2c_target_write_rx.sv
// Bench for i2c_target_write_rx: bus-master tasks, vector table, random model.
module tb_i2c_target_write_rx;
  import i2c_globals_pkg::*;
  localparam int T = 8;

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       data_ready = 1'b1;
  logic [6:0] own_addr = 7'h50;
  logic       scl_i, sda_i, sda_oe, scl_oe;
  logic [7:0] reg_addr, data, txn_bytes;
  logic [6:0] byte_index;
  logic       reg_addr_valid, data_valid, txn_done, overflow_err;

  assign scl_i = scl_m & ~scl_oe;
  assign sda_i = sda_m & ~sda_oe;
  always #5 pclk = ~pclk;

  i2c_target_write_rx dut (
    .pclk(pclk), .areset(areset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .own_addr(own_addr),
    .reg_addr(reg_addr), .reg_addr_valid(reg_addr_valid),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .byte_index(byte_index), .txn_done(txn_done),
    .txn_bytes(txn_bytes), .overflow_err(overflow_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Observed traffic
  logic [7:0]  ra_q [$];
  logic [14:0] dq   [$];
  logic [7:0]  td_q [$];
  bit          oe_seen;
  bit          acks [$];
  logic [7:0]  pay  [0:199];

  always @(negedge pclk) begin
    if (!areset) begin
      if (reg_addr_valid) ra_q.push_back(reg_addr);
      if (data_valid && data_ready) dq.push_back({byte_index, data});
      if (txn_done) td_q.push_back(txn_bytes);
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  logic        pv = 1'b0;
  logic [14:0] pd;
  always @(negedge pclk) begin
    if (pv && data_valid) chk("data_stable", {byte_index, data}, pd);
    pv = data_valid && !data_ready;
    pd = {byte_index, data};
  end

  task automatic wt(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic scl_high();
    int k = 0;
    scl_m = 1'b1;
    while (!scl_i && k < 4000) begin wt(1); k++; end
    if (!scl_i) chk("scl_release_timeout", 0, 1);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wt(T); scl_high(); wt(T);
    sda_m = 1'b0; wt(T); scl_m = 1'b0; wt(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wt(T); scl_high(); wt(T);
    sda_m = 1'b1; wt(T);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wt(T); scl_high(); wt(T);
      scl_m = 1'b0; wt(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit a;
    send_bits(b);
    sda_m = 1'b1; wt(T); scl_high(); wt(T/2);
    a = !sda_i;
    wt(T/2); scl_m = 1'b0; wt(2);
    acks.push_back(a);
  endtask

  task automatic clear_obs();
    ra_q.delete(); dq.delete(); td_q.delete(); acks.delete();
    oe_seen = 1'b0;
  endtask

  task automatic do_txn(input logic [6:0] a, input bit rw,
                        input logic [7:0] r, input int n);
    bus_start();
    chk("ovf_clear_on_start", overflow_err, 0);
    send_byte({a, rw});
    if (acks[0]) begin
      send_byte(r);
      for (int i = 0; i < n; i++) begin
        send_byte(pay[i]);
        if (!acks[acks.size()-1]) break;
      end
    end
    bus_stop();
  endtask

  typedef struct {
    logic [6:0] own, addr;
    bit         rw;
    logic [7:0] rg;
    int         n;
    logic [7:0] b0, b1;
    bit         rdy;
    int         e_ackn;
    logic [7:0] e_ackv;
    bit         e_reg;
    int         e_nd;
    bit         e_done;
    logic [7:0] e_tb;
    bit         e_ovf;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [7:0] av;
    int bad, ones, n;
    logic [6:0] a;
    bit rw, match;
    logic [7:0] rg;

    vt[0] = '{7'h50, 7'h50, 0, 8'h1A, 2, 8'hDE, 8'hAD, 1, 4, 8'h0F, 1, 2, 1, 8'd2, 0};
    vt[1] = '{7'h50, 7'h51, 0, 8'h1A, 2, 8'hDE, 8'hAD, 1, 1, 8'h00, 0, 0, 0, 8'd0, 0};
    vt[2] = '{7'h50, 7'h50, 1, 8'h1A, 2, 8'hDE, 8'hAD, 1, 1, 8'h00, 0, 0, 0, 8'd0, 0};
    vt[3] = '{7'h50, 7'h50, 0, 8'h05, 2, 8'h11, 8'h22, 0, 4, 8'h07, 1, 1, 1, 8'd1, 1};
    vt[4] = '{7'h50, 7'h50, 0, 8'h80, 0, 8'h00, 8'h00, 1, 2, 8'h03, 1, 0, 1, 8'd0, 0};
    vt[5] = '{7'h2A, 7'h2A, 0, 8'hFF, 1, 8'h00, 8'h00, 1, 3, 8'h07, 1, 1, 1, 8'd1, 0};
    vt[6] = '{7'h2A, 7'h50, 0, 8'h44, 1, 8'h99, 8'h00, 1, 1, 8'h00, 0, 0, 0, 8'd0, 0};

    wt(4);
    chk("reset_outputs",
        {sda_oe, scl_oe, reg_addr, reg_addr_valid, data, data_valid,
         byte_index, txn_done, txn_bytes, overflow_err}, 0);
    areset = 1'b0;
    wt(T);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      clear_obs();
      own_addr = vt[v].own;
      data_ready = vt[v].rdy;
      pay[0] = vt[v].b0;
      pay[1] = vt[v].b1;
      do_txn(vt[v].addr, vt[v].rw, vt[v].rg, vt[v].n);
      chk($sformatf("v%0d_overflow", v), overflow_err, vt[v].e_ovf);
      data_ready = 1'b1;
      wt(4);
      av = '0;
      foreach (acks[i]) if (i < 8) av[i] = acks[i];
      chk($sformatf("v%0d_ack_count", v), acks.size(), vt[v].e_ackn);
      chk($sformatf("v%0d_ack_bits", v), av, vt[v].e_ackv);
      chk($sformatf("v%0d_sda_oe_seen", v), oe_seen, av != 0);
      chk($sformatf("v%0d_reg_pulses", v), ra_q.size(), vt[v].e_reg);
      if (ra_q.size() > 0)
        chk($sformatf("v%0d_reg_addr", v), ra_q[0], vt[v].rg);
      chk($sformatf("v%0d_data_count", v), dq.size(), vt[v].e_nd);
      foreach (dq[i])
        chk($sformatf("v%0d_data%0d", v, i), dq[i], {7'(i), pay[i]});
      chk($sformatf("v%0d_done_pulses", v), td_q.size(), vt[v].e_done);
      if (td_q.size() > 0)
        chk($sformatf("v%0d_txn_bytes", v), td_q[0], vt[v].e_tb);
    end

    // Repeated START restarts the FSM; first transaction never completes
    clear_obs();
    own_addr = 7'h50;
    bus_start();
    send_byte(8'hA0); send_byte(8'h77);
    bus_start();
    send_byte(8'hA0); send_byte(8'h33); send_byte(8'h44);
    bus_stop();
    wt(4);
    ones = 0;
    foreach (acks[i]) ones += acks[i];
    chk("rs_acks", ones, 5);
    chk("rs_reg_pulses", ra_q.size(), 2);
    if (ra_q.size() == 2) chk("rs_second_reg", ra_q[1], 8'h33);
    chk("rs_done_pulses", td_q.size(), 1);
    if (td_q.size() == 1) chk("rs_txn_bytes", td_q[0], 1);
    chk("rs_data_count", dq.size(), 1);
    if (dq.size() == 1) chk("rs_data", dq[0], {7'd0, 8'h44});

    // Reset while the target drives ACK
    clear_obs();
    bus_start();
    send_byte(8'hA0); send_byte(8'h10);
    send_bits(8'h5C);
    bad = 0;
    while (!sda_oe && bad < 40) begin wt(1); bad++; end
    chk("mid_reset_ack_driven", sda_oe, 1);
    areset = 1'b1;
    wt(1);
    chk("mid_reset_outputs",
        {sda_oe, scl_oe, reg_addr, reg_addr_valid, data, data_valid,
         byte_index, txn_done, txn_bytes, overflow_err}, 0);
    areset = 1'b0;
    sda_m = 1'b1; wt(T); scl_high(); wt(2 * T);
    clear_obs();
    pay[0] = 8'h99;
    do_txn(7'h50, 1'b0, 8'h5A, 1);
    wt(4);
    chk("post_reset_acks", acks.size() == 3 && acks[0] && acks[1] && acks[2], 1);
    chk("post_reset_reg", ra_q.size() == 1 ? ra_q[0] : 8'hxx, 8'h5A);
    chk("post_reset_data", dq.size() == 1 ? dq[0] : 15'hx, {7'd0, 8'h99});
    chk("post_reset_done", td_q.size() == 1 ? td_q[0] : 8'hxx, 1);

    // Byte-count limit: byte MAXIMUM_BYTES+1 is NACKed, no overflow
    clear_obs();
    for (int i = 0; i < 129; i++) pay[i] = 8'(i * 7 + 3);
    do_txn(7'h50, 1'b0, 8'h01, 129);
    chk("max_overflow", overflow_err, 0);
    wt(4);
    ones = 0;
    foreach (acks[i]) if (i < 130) ones += acks[i];
    chk("max_ack_count", acks.size(), 131);
    chk("max_acked", ones, 130);
    if (acks.size() == 131) chk("max_last_nack", acks[130], 0);
    chk("max_data_count", dq.size(), 128);
    bad = 0;
    foreach (dq[i]) if (dq[i] !== {7'(i), pay[i]}) bad++;
    chk("max_data_values", bad, 0);
    chk("max_txn_bytes", td_q.size() == 1 ? td_q[0] : 8'hxx, 8'd128);

    // Random transactions against an abstract model
    for (int t = 0; t < 12; t++) begin
      clear_obs();
      own_addr = 7'($urandom_range(8, 119));
      a = ($urandom_range(0, 2) == 0) ?
          own_addr ^ 7'($urandom_range(1, 127)) : own_addr;
      rw = ($urandom_range(0, 3) == 0);
      rg = 8'($urandom);
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      match = (a == own_addr) && !rw;
      do_txn(a, rw, rg, n);
      wt(4);
      bad = 0;
      if (acks.size() != (match ? n + 2 : 1)) bad++;
      foreach (acks[i]) if (acks[i] != match) bad++;
      chk($sformatf("rnd%0d_acks", t), bad, 0);
      chk($sformatf("rnd%0d_reg", t), ra_q.size() == 1 ? ra_q[0] : 8'hxx,
          match ? rg : 8'hxx);
      bad = (dq.size() != (match ? n : 0)) ? 1 : 0;
      foreach (dq[i]) if (dq[i] !== {7'(i), pay[i]}) bad++;
      chk($sformatf("rnd%0d_data", t), bad, 0);
      chk($sformatf("rnd%0d_done", t), td_q.size() == 1 ? td_q[0] : 8'hxx,
          match ? 8'(n) : 8'hxx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
